// File: rtl/dot_product_stream.sv
// Streaming LANES-wide dot-product engine: 3-stage pipeline plus accumulator/result register.
// Define DOTP_SATURATE_EN for a clamping accumulator with a sticky per-vector overflow flag.
module dot_product_stream #(
  parameter int LANES          = 4,
  parameter int ELEM_WIDTH     = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*ELEM_WIDTH-1:0] in_a,
  input  logic [LANES*ELEM_WIDTH-1:0] in_b,
  input  logic                        in_last,
  input  logic                        signed_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_result,
  output logic [BEAT_CNT_WIDTH-1:0]   out_beats,
  output logic                        out_overflow
);

  localparam int DATA_WIDTH = LANES * ELEM_WIDTH;
  localparam int PROD_WIDTH = 2 * ELEM_WIDTH;
`ifdef DOTP_SATURATE_EN
  localparam int SUM_WIDTH  = ACC_WIDTH + PROD_WIDTH + $clog2(LANES) + 2;
`else
  localparam int SUM_WIDTH  = ACC_WIDTH;
`endif

  logic                      w_stall;
  logic                      w_beat_mode;
  logic                      r_in_first, r_vec_mode;
  logic                      r_s1_valid, r_s1_last, r_s1_first, r_s1_mode;
  logic [DATA_WIDTH-1:0]     r_s1_a, r_s1_b;
  logic                      r_s2_valid, r_s2_last, r_s2_first;
  logic [SUM_WIDTH-1:0]      w_prod    [LANES];
  logic [SUM_WIDTH-1:0]      r_s2_prod [LANES];
  logic                      r_s3_valid, r_s3_last, r_s3_first;
  logic [SUM_WIDTH-1:0]      w_lane_sum, r_s3_sum, w_base, w_total;
  logic [ACC_WIDTH-1:0]      r_acc, w_acc_next;
  logic [BEAT_CNT_WIDTH-1:0] r_cnt, w_cnt_next;
  logic                      r_out_valid;
  logic [ACC_WIDTH-1:0]      r_out_result;
  logic [BEAT_CNT_WIDTH-1:0] r_out_beats;

  // A result the consumer has not taken freezes the whole pipeline.
  assign w_stall     = r_out_valid && !out_ready;
  assign in_ready    = !w_stall;
  assign w_beat_mode = r_in_first ? signed_mode : r_vec_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_first <= 1'b1;
      r_vec_mode <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      if (in_valid) begin
        r_in_first <= in_last;
        if (r_in_first) r_vec_mode <= signed_mode;
      end
    end
  end

  // NOTE: datapath registers carry no reset; every consumer qualifies them with a stage valid.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_last  <= in_last;
      r_s1_first <= r_in_first;
      r_s1_mode  <= w_beat_mode;
      r_s2_prod  <= w_prod;
      r_s2_last  <= r_s1_last;
      r_s2_first <= r_s1_first;
      r_s3_sum   <= w_lane_sum;
      r_s3_last  <= r_s2_last;
      r_s3_first <= r_s2_first;
    end
  end

  // Operands widened by mode so one unsigned multiplier serves both signed and unsigned lanes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ELEM_WIDTH-1:0] w_ea, w_eb;
    logic [PROD_WIDTH-1:0] w_xa, w_xb, w_p;
    assign w_ea = r_s1_a[g*ELEM_WIDTH +: ELEM_WIDTH];
    assign w_eb = r_s1_b[g*ELEM_WIDTH +: ELEM_WIDTH];
    assign w_xa = {{ELEM_WIDTH{r_s1_mode & w_ea[ELEM_WIDTH-1]}}, w_ea};
    assign w_xb = {{ELEM_WIDTH{r_s1_mode & w_eb[ELEM_WIDTH-1]}}, w_eb};
    assign w_p  = w_xa * w_xb;
    if (SUM_WIDTH > PROD_WIDTH) begin : g_ext
      assign w_prod[g] = {{(SUM_WIDTH-PROD_WIDTH){r_s1_mode & w_p[PROD_WIDTH-1]}}, w_p};
    end else begin : g_noext
      assign w_prod[g] = w_p[SUM_WIDTH-1:0];
    end
  end

  // NOTE: blocking assignments in always_comb, with a default first so no latch is inferred.
  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++) w_lane_sum = w_lane_sum + r_s2_prod[i];
  end

  assign w_cnt_next = r_s3_first ? BEAT_CNT_WIDTH'(1)
                    : (&r_cnt ? r_cnt : r_cnt + 1'b1);

`ifdef DOTP_SATURATE_EN
  localparam logic [SUM_WIDTH-1:0] SMAX = {{(SUM_WIDTH-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0] SMIN = {{(SUM_WIDTH-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [SUM_WIDTH-1:0] UMAX = {{(SUM_WIDTH-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

  logic r_s2_mode, r_s3_mode, r_ovf, r_out_ovf, w_clamp, w_ovf_next;

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s2_mode <= r_s1_mode;
      r_s3_mode <= r_s2_mode;
    end
  end

  assign w_base  = r_s3_first ? '0 : {{(SUM_WIDTH-ACC_WIDTH){r_s3_mode & r_acc[ACC_WIDTH-1]}}, r_acc};
  assign w_total = w_base + r_s3_sum;

  always_comb begin
    w_acc_next = w_total[ACC_WIDTH-1:0];
    w_clamp    = 1'b0;
    if (r_s3_mode) begin
      if ($signed(w_total) > $signed(SMAX)) begin
        w_acc_next = SMAX[ACC_WIDTH-1:0];
        w_clamp    = 1'b1;
      end else if ($signed(w_total) < $signed(SMIN)) begin
        w_acc_next = SMIN[ACC_WIDTH-1:0];
        w_clamp    = 1'b1;
      end
    end else if (w_total > UMAX) begin
      w_acc_next = UMAX[ACC_WIDTH-1:0];
      w_clamp    = 1'b1;
    end
  end

  assign w_ovf_next = (!r_s3_first && r_ovf) || w_clamp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (!w_stall && r_s3_valid) begin
      r_ovf <= w_ovf_next;
      if (r_s3_last) r_out_ovf <= w_ovf_next;
    end
  end

  assign out_overflow = r_out_ovf;
`else
  assign w_base       = r_s3_first ? '0 : r_acc;
  assign w_total      = w_base + r_s3_sum;
  assign w_acc_next   = w_total;
  assign out_overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_beats  <= '0;
    end else begin
      if (!w_stall && r_s3_valid) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
      if (!w_stall && r_s3_valid && r_s3_last) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_acc_next;
        r_out_beats  <= w_cnt_next;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_beats  = r_out_beats;

endmodule
